// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode encodings and flag bit positions shared by the ALU pipeline
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    // flags bus is {N,Z,C,V}
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath: opcode/a/b to result and {N,Z,C,V}
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] shl_w;
    logic [WIDTH:0] shr_w;
    logic           carry;
    logic           ovf;

    assign shamt = b[SHW-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    // One guard bit beside the operand captures the last bit shifted out (0 when shamt is 0).
    assign shl_w = {1'b0, a} << shamt;
    assign shr_w = {a, 1'b0} >> shamt;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOT: result = ~a;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = shl_w[WIDTH-1:0];
                carry  = shl_w[WIDTH];
            end
            default: begin
                result = shr_w[WIDTH:1];
                carry  = shr_w[0];
            end
        endcase
    end

    always_comb begin
        flags        = 4'b0000;
        flags[FLG_N] = result[WIDTH-1];
        flags[FLG_Z] = (result == '0);
        flags[FLG_C] = carry;
        flags[FLG_V] = ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline with valid/ready handshakes on both sides
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    logic             a_valid;
    logic [2:0]       a_op;
    logic [WIDTH-1:0] a_a;
    logic [WIDTH-1:0] a_b;
    logic             adv_a;
    logic             adv_b;
    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flg;

    assign adv_b    = !out_valid || out_ready;
    assign adv_a    = !a_valid || adv_b;
    assign in_ready = adv_a;

    // Operand registers load only for a real op, so X on idle inputs never propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_op    <= OP_ADD;
            a_a     <= '0;
            a_b     <= '0;
        end else if (adv_a) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_op <= opcode;
                a_a  <= a;
                a_b  <= b;
            end
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode (a_op),
        .a      (a_a),
        .b      (a_b),
        .result (core_res),
        .flags  (core_flg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= 4'b0000;
        end else if (adv_b) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out   <= core_res;
                flags <= core_flg;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH 8 and 16
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  opcode;
    logic [7:0]  a, b, out;
    logic [3:0]  flags;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [2:0]  w_opcode;
    logic [15:0] w_a, w_b, w_out;
    logic [3:0]  w_flags;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags)
    );

    alu_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .opcode(w_opcode), .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out(w_out), .flags(w_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input logic [2:0] op, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] eo, input logic [3:0] ef);
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        opcode   = 'x;
        a        = 'x;
        b        = 'x;
        chk({tag, "_lat"}, out_valid, 1'b0);
        tick();
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_flg"}, flags, ef);
    endtask

    task automatic op16(input string tag, input logic [2:0] op, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] eo, input logic [3:0] ef);
        w_opcode   = op;
        w_a        = av;
        w_b        = bv;
        w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        tick();
        chk({tag, "_vld"}, w_out_valid, 1'b1);
        chk({tag, "_out"}, w_out, eo);
        chk({tag, "_flg"}, w_flags, ef);
    endtask

    logic [7:0] exp_q[$];
    int         sent, recv, ir_low;
    bit         m_a, m_b, n_a, n_b, stalled_prev;
    logic [7:0] held_o;
    logic [3:0] held_f;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        opcode      = 3'd0;
        a           = 8'h00;
        b           = 8'h00;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        w_opcode    = 3'd0;
        w_a         = 16'h0000;
        w_b         = 16'h0000;
        #2;
        chk("rst_ir",  in_ready,  1'b1);
        chk("rst_ov",  out_valid, 1'b0);
        chk("rst_out", out,       8'h00);
        chk("rst_flg", flags,     4'h0);
        #10 rst_n = 1'b1;
        tick();

        // {N,Z,C,V}
        op8("add_c",   3'd0, 8'd200, 8'd100, 8'd44,  4'b0010);
        op8("add_v",   3'd0, 8'd100, 8'd50,  8'd150, 4'b1001);
        op8("sub_b",   3'd1, 8'd5,   8'd6,   8'd255, 4'b1010);
        op8("sub_z",   3'd1, 8'd15,  8'd15,  8'd0,   4'b0100);
        op8("not",     3'd4, 8'h0F,  8'h00,  8'hF0,  4'b1000);
        op8("and",     3'd2, 8'hF0,  8'h3C,  8'h30,  4'b0000);
        op8("or",      3'd3, 8'hF0,  8'h0F,  8'hFF,  4'b1000);
        op8("xor",     3'd5, 8'hAA,  8'hAA,  8'h00,  4'b0100);
        op8("shl1",    3'd6, 8'h81,  8'd1,   8'h02,  4'b0010);
        op8("shr9",    3'd7, 8'h81,  8'd9,   8'h40,  4'b0010);
        op8("shr0",    3'd7, 8'h81,  8'd0,   8'h81,  4'b1000);
        tick();
        chk("bubble_ov", out_valid, 1'b0);

        sent = 0; recv = 0; ir_low = 0;
        m_a = 1'b0; m_b = 1'b0; stalled_prev = 1'b0;
        held_o = 8'h00; held_f = 4'h0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 8);
            opcode    = 3'd0;
            a         = 8'(sent * 20 + 1);
            b         = 8'(sent * 7 + 3);
            #1;
            chk("strm_ir", in_ready, !(m_a && m_b && !out_ready));
            chk("strm_ov", out_valid, m_b);
            if (stalled_prev) begin
                chk("stall_out", out, held_o);
                chk("stall_flg", flags, held_f);
            end
            if (!in_ready) ir_low++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("strm_extra", 1'b1, 1'b0);
                else                   chk("strm_data", out, exp_q.pop_front());
                recv++;
            end
            stalled_prev = out_valid && !out_ready;
            held_o       = out;
            held_f       = flags;
            if (in_valid && in_ready) begin
                exp_q.push_back(8'(a + b));
                sent++;
            end
            n_b = (!m_b || out_ready) ? m_a : m_b;
            n_a = (!m_a || !m_b || out_ready) ? in_valid : m_a;
            m_a = n_a;
            m_b = n_b;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("strm_cnt",   recv, 8);
        chk("strm_irlow", ir_low > 0, 1'b1);
        tick();

        opcode = 3'd0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
        tick();
        a = 8'd3; b = 8'd4;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_ov",  out_valid, 1'b1);
        chk("pre_rst_out", out, 8'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov",  out_valid, 1'b0);
        chk("mid_rst_out", out, 8'h00);
        chk("mid_rst_flg", flags, 4'h0);
        chk("mid_rst_ir",  in_ready, 1'b1);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_ir", in_ready, 1'b1);
        chk("post_rst_ov", out_valid, 1'b0);
        op8("post_rst", 3'd0, 8'd10, 8'd20, 8'd30, 4'b0000);

        op16("w_add", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
        op16("w_shl", 3'd6, 16'h1234, 16'h0013, 16'h91A0, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
